// File: rtl/shifter_arbiter.sv
// shifter_arbiter
//   Two requesters share one 16-bit shifter. One request is granted per cycle,
//   either round-robin or fixed priority (req0 wins). The result is registered
//   in a single output stage that has its own valid/ready handshake and an id tag
//   naming the requester.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   reqN_valid/reqN_ready   request handshake for requester N (N = 0, 1)
//   reqN_data [15:0]        operand
//   reqN_amt  [3:0]         shift amount
//   reqN_mode [1:0]         0 = SLL, 1 = SRA, 2 = ROR, 3 = pass-through
//   rsp_valid/rsp_ready     result handshake
//   rsp_data  [15:0]        shifted result
//   rsp_id                  requester that owns rsp_data
//   busy                    rsp_valid | req0_valid | req1_valid (status only)
module shifter_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_data,
   input  logic [3:0]  req0_amt,
   input  logic [1:0]  req0_mode,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_data,
   input  logic [3:0]  req1_amt,
   input  logic [1:0]  req1_mode,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_id,
   output logic        busy
);

   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_data_q, rsp_data_d;
   logic        rsp_id_q, rsp_id_d;
   logic        last_grant_q, last_grant_d;

   logic        free;
   logic        grant;        // requester index selected this cycle
   logic        grant_valid;  // a request is accepted this cycle

   logic [15:0] sh_data;
   logic [3:0]  sh_amt;
   logic [1:0]  sh_mode;
   logic [31:0] sh_rot;
   logic [15:0] sh_res;

   // Arbitration
   always_comb begin
      free = ~rsp_valid_q | rsp_ready;
      if (req0_valid & req1_valid) begin
         grant = RR_EN ? ~last_grant_q : 1'b0;
      end else begin
         grant = req1_valid;
      end
      // rst_n gating keeps both readies low for the whole reset interval.
      grant_valid = rst_n & free & (req0_valid | req1_valid);
   end

   assign req0_ready = grant_valid & ~grant;
   assign req1_ready = grant_valid & grant;

   // Shifter operand mux; idle inputs are forced to zero so X never propagates.
   always_comb begin
      sh_data = '0;
      sh_amt  = '0;
      sh_mode = '0;
      if (grant_valid) begin
         if (grant) begin
            sh_data = req1_data;
            sh_amt  = req1_amt;
            sh_mode = req1_mode;
         end else begin
            sh_data = req0_data;
            sh_amt  = req0_amt;
            sh_mode = req0_mode;
         end
      end
   end

   // Shifter datapath (purely combinational)
   always_comb begin
      // Rotate via a doubled word: the low half after shifting is the rotation.
      sh_rot = {sh_data, sh_data} >> sh_amt;
      case (sh_mode)
         2'd0:    sh_res = sh_data << sh_amt;
         2'd1:    sh_res = $unsigned($signed(sh_data) >>> sh_amt);
         2'd2:    sh_res = sh_rot[15:0];
         default: sh_res = sh_data;
      endcase
   end

   // Output stage next state
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_id_d     = rsp_id_q;
      last_grant_d = last_grant_q;
      if (grant_valid) begin
         // Covers simultaneous drain and accept: new result replaces old, no bubble.
         rsp_valid_d  = 1'b1;
         rsp_data_d   = sh_res;
         rsp_id_d     = grant;
         last_grant_d = grant;
      end else if (rsp_valid_q & rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= 16'h0000;
         rsp_id_q     <= 1'b0;
         last_grant_q <= 1'b1;  // req0 wins the first tie after reset
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_id_q     <= rsp_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = rsp_valid_q | req0_valid | req1_valid;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Testbench for shifter_arbiter. Two instances (round-robin and fixed priority)
// share stimulus; a negedge monitor models the arbiter and a result queue for
// whichever instance is selected, plus directed checks for the listed scenarios.
module tb_shifter_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        v0, v1, rsp_ready;
   logic [15:0] d0, d1;
   logic [3:0]  a0, a1;
   logic [1:0]  m0, m1;

   logic        rr_r0, rr_r1, rr_rv, rr_id, rr_busy;
   logic [15:0] rr_rd;
   logic        fp_r0, fp_r1, fp_rv, fp_id, fp_busy;
   logic [15:0] fp_rd;

   int          n_vec = 0;
   int          n_err = 0;
   logic        sel = 1'b0;  // 0: check round-robin instance, 1: fixed priority

   typedef struct packed {
      logic        id;
      logic [15:0] data;
   } rsp_t;
   rsp_t sb[$];

   always #5 clk = ~clk;

   shifter_arbiter #(.RR_EN(1'b1)) dut_rr (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(rr_r0), .req0_data(d0), .req0_amt(a0), .req0_mode(m0),
      .req1_valid(v1), .req1_ready(rr_r1), .req1_data(d1), .req1_amt(a1), .req1_mode(m1),
      .rsp_valid(rr_rv), .rsp_ready(rsp_ready), .rsp_data(rr_rd), .rsp_id(rr_id),
      .busy(rr_busy)
   );

   shifter_arbiter #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(fp_r0), .req0_data(d0), .req0_amt(a0), .req0_mode(m0),
      .req1_valid(v1), .req1_ready(fp_r1), .req1_data(d1), .req1_amt(a1), .req1_mode(m1),
      .rsp_valid(fp_rv), .rsp_ready(rsp_ready), .rsp_data(fp_rd), .rsp_id(fp_id),
      .busy(fp_busy)
   );

   wire        o_r0   = sel ? fp_r0   : rr_r0;
   wire        o_r1   = sel ? fp_r1   : rr_r1;
   wire        o_rv   = sel ? fp_rv   : rr_rv;
   wire        o_id   = sel ? fp_id   : rr_id;
   wire        o_busy = sel ? fp_busy : rr_busy;
   wire [15:0] o_rd   = sel ? fp_rd   : rr_rd;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Bit-by-bit reference shifter.
   function automatic logic [15:0] shift_model(input logic [15:0] d, input logic [3:0] amt,
                                               input logic [1:0] mode);
      logic [15:0] r;
      int          src;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         src = i + int'(amt);
         case (mode)
            2'd0: r[i] = (i >= int'(amt)) ? d[i - int'(amt)] : 1'b0;
            2'd1: r[i] = (src > 15) ? d[15] : d[src];
            2'd2: r[i] = d[src % 16];
            default: r[i] = d[i];
         endcase
      end
      return r;
   endfunction

   // Reference model and scoreboard, evaluated mid-cycle.
   logic m_valid = 1'b0;
   logic m_last  = 1'b1;
   always @(negedge clk) begin
      logic free, any, g;
      rsp_t e;
      if (!rst_n) begin
         m_valid = 1'b0;
         m_last  = 1'b1;
         sb.delete();
         check_eq("rst_rdy0", o_r0, 0);
         check_eq("rst_rdy1", o_r1, 0);
         check_eq("rst_rsp_valid", o_rv, 0);
      end else begin
         free = !m_valid || rsp_ready;
         any  = free && (v0 || v1);
         if (v0 && v1) g = sel ? 1'b0 : !m_last;
         else          g = v1;
         check_eq("rdy0", o_r0, any && !g);
         check_eq("rdy1", o_r1, any && g);
         check_eq("rsp_valid", o_rv, m_valid);
         check_eq("busy", o_busy, m_valid || v0 || v1);
         if (m_valid) begin
            if (sb.size() == 0) begin
               check_eq("sb_empty", 1, 0);
            end else begin
               check_eq("rsp_data", o_rd, sb[0].data);
               check_eq("rsp_id", o_id, sb[0].id);
               if (rsp_ready) void'(sb.pop_front());
            end
         end
         if (any) begin
            e.id   = g;
            e.data = g ? shift_model(d1, a1, m1) : shift_model(d0, a0, m0);
            sb.push_back(e);
            m_valid = 1'b1;
            m_last  = g;
         end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Advance n cycles; return 1 time unit after the last rising edge.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      v0 = 0; v1 = 0; rsp_ready = 0;
      cyc(2);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc0, acc1;
      rst_n = 1'b0;
      v0 = 0; v1 = 0; rsp_ready = 0;
      d0 = 0; d1 = 0; a0 = 0; a1 = 0; m0 = 0; m1 = 0;
      cyc(2);
      check_eq("reset_rsp_data", rr_rd, 16'h0000);
      check_eq("reset_rsp_id", rr_id, 0);
      rst_n = 1'b1;
      cyc(1);

      // Single request: SRA 0x8001 by 1
      v0 = 1; d0 = 16'h8001; a0 = 1; m0 = 2'd1; rsp_ready = 1;
      #3 check_eq("single_rdy0", rr_r0, 1);
      cyc(1);
      v0 = 0;
      check_eq("single_valid", rr_rv, 1);
      check_eq("single_data", rr_rd, 16'hC000);
      check_eq("single_id", rr_id, 0);
      cyc(1);

      // Tie right after reset: req0 first, then req1
      do_reset();
      cyc(1);
      rsp_ready = 1;
      v0 = 1; d0 = 16'h0001; a0 = 4; m0 = 2'd0;
      v1 = 1; d1 = 16'h0001; a1 = 1; m1 = 2'd2;
      #3 check_eq("tie_c1_rdy0", rr_r0, 1);
      check_eq("tie_c1_rdy1", rr_r1, 0);
      cyc(1);
      check_eq("tie_c1_data", rr_rd, 16'h0010);
      check_eq("tie_c1_id", rr_id, 0);
      #3 check_eq("tie_c2_rdy0", rr_r0, 0);
      check_eq("tie_c2_rdy1", rr_r1, 1);
      cyc(1);
      v0 = 0; v1 = 0;
      check_eq("tie_c2_data", rr_rd, 16'h8000);
      check_eq("tie_c2_id", rr_id, 1);
      cyc(1);

      // Backpressure with req1 waiting
      v0 = 1; d0 = 16'h000F; a0 = 4; m0 = 2'd0; rsp_ready = 1;
      cyc(1);
      v0 = 0; rsp_ready = 0;
      v1 = 1; d1 = 16'h8000; a1 = 3; m1 = 2'd1;
      for (int i = 0; i < 3; i++) begin
         #3 check_eq("bp_hold_data", rr_rd, 16'h00F0);
         check_eq("bp_rdy1", rr_r1, 0);
         cyc(1);
      end
      rsp_ready = 1;
      #3 check_eq("bp_release_rdy1", rr_r1, 1);
      cyc(1);
      v1 = 0;
      check_eq("bp_new_valid", rr_rv, 1);
      check_eq("bp_new_data", rr_rd, 16'hF000);
      check_eq("bp_new_id", rr_id, 1);
      cyc(1);

      // Edge cases back to back from req0
      begin
         logic [15:0] ed [4] = '{16'h1234, 16'h0001, 16'h7FFF, 16'hFFFF};
         logic [1:0]  em [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
         logic [15:0] ex [4] = '{16'h1234, 16'h0002, 16'h0000, 16'h8000};
         for (int i = 0; i < 4; i++) begin
            v0 = 1; d0 = ed[i]; a0 = 15; m0 = em[i];
            cyc(1);
            check_eq("edge_data", rr_rd, ex[i]);
         end
         v0 = 0;
         cyc(1);
      end

      // Random traffic with random backpressure; requesters hold while stalled
      v0 = 0; v1 = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         acc0 = v0 && rr_r0;
         acc1 = v1 && rr_r1;
         cyc(1);
         if (!v0 || acc0) begin
            v0 = $urandom_range(0, 1); d0 = 16'($urandom); a0 = 4'($urandom); m0 = 2'($urandom);
         end
         if (!v1 || acc1) begin
            v1 = $urandom_range(0, 1); d1 = 16'($urandom); a1 = 4'($urandom); m1 = 2'($urandom);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      v0 = 0; v1 = 0; rsp_ready = 1;
      cyc(2);

      // Asynchronous reset with a pending result
      v0 = 1; d0 = 16'h00FF; a0 = 8; m0 = 2'd0; rsp_ready = 0;
      cyc(1);
      v0 = 1; v1 = 1;
      check_eq("ar_pending", rr_rv, 1);
      #1 rst_n = 1'b0;
      #1 check_eq("ar_valid_clr", rr_rv, 0);
      check_eq("ar_rdy0_clr", rr_r0, 0);
      check_eq("ar_rdy1_clr", rr_r1, 0);
      #4 v0 = 0; v1 = 0;
      rst_n = 1'b1;
      cyc(1);
      check_eq("ar_no_stale", rr_rv, 0);
      v1 = 1; d1 = 16'h0F00; a1 = 4; m1 = 2'd2; rsp_ready = 1;
      cyc(1);
      v1 = 0;
      check_eq("ar_new_valid", rr_rv, 1);
      check_eq("ar_new_id", rr_id, 1);
      check_eq("ar_new_data", rr_rd, 16'h00F0);
      cyc(1);

      // Fixed priority instance
      rst_n = 1'b0;
      v0 = 0; v1 = 0;
      cyc(1);
      sel = 1'b1;
      cyc(1);
      rst_n = 1'b1;
      cyc(1);
      rsp_ready = 1;
      v1 = 1; d1 = 16'hABCD; a1 = 0; m1 = 2'd0;
      v0 = 1; a0 = 1; m0 = 2'd0;
      for (int i = 0; i < 8; i++) begin
         d0 = 16'(i + 1);
         #3 check_eq("fp_rdy1_low", fp_r1, 0);
         cyc(1);
         check_eq("fp_id0", fp_id, 0);
         check_eq("fp_data", fp_rd, 16'((i + 1) * 2));
      end
      v0 = 0;
      #3 check_eq("fp_rdy1_high", fp_r1, 1);
      cyc(1);
      v1 = 0;
      check_eq("fp_req1_id", fp_id, 1);
      check_eq("fp_req1_data", fp_rd, 16'hABCD);
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
